// File: rtl/reg_file_sb.sv
// Decode-stage register file: NRD combinational read ports, one write port with
// write-through bypass, and a busy-bit scoreboard tracking outstanding producers.
module reg_file_sb #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int AW      = $clog2(NREG),
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [XLEN-1:0]            wdata,
    input  logic [NRD*AW-1:0]          raddr,
    output logic [NRD*XLEN-1:0]        rdata,
    output logic [NRD-1:0]             rbusy,
    input  logic                       iss_valid,
    input  logic [AW-1:0]              iss_rd,
    input  logic                       flush,
    output logic                       iss_stall,
    output logic [$clog2(NREG+1)-1:0]  busy_cnt
);

    localparam int CW = $clog2(NREG+1);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_busy_cnt;

    logic w_wr_zero;
    logic w_iss_zero;
    logic w_set_hit;
    logic w_clr_hit;
    logic w_set_eff;
    logic w_clr_eff;

    assign w_wr_zero  = (ZERO_R0 != 0) && (waddr == '0);
    assign w_iss_zero = (ZERO_R0 != 0) && (iss_rd == '0);
    assign w_set_hit  = iss_valid && !flush && !w_iss_zero;
    assign w_clr_hit  = we && !w_wr_zero;

    // Count deltas only reflect real bit transitions; a same-register set masks the clear.
    assign w_set_eff = w_set_hit && !r_busy[iss_rd];
    assign w_clr_eff = w_clr_hit && r_busy[waddr] && !(w_set_hit && (iss_rd == waddr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && !w_wr_zero) begin
            r_regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else if (flush) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_clr_hit) begin
                r_busy[waddr] <= 1'b0;
            end
            if (w_set_hit) begin
                r_busy[iss_rd] <= 1'b1;
            end
            r_busy_cnt <= r_busy_cnt + CW'(w_set_eff) - CW'(w_clr_eff);
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_zero;
        logic          w_byp;

        assign w_ra   = raddr[g*AW +: AW];
        assign w_zero = (ZERO_R0 != 0) && (w_ra == '0);
        assign w_byp  = we && (waddr == w_ra);

        assign rdata[g*XLEN +: XLEN] = (!rst || w_zero) ? '0 :
                                       (w_byp ? wdata : r_regs[w_ra]);
        assign rbusy[g] = rst && !w_zero && r_busy[w_ra] && !w_byp;
    end

    assign iss_stall = rst && iss_valid && (|rbusy);
    assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed vectors with literal expectations, plus an
// array-based reference model checked against every output each cycle.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int CW   = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                we = 1'b0;
    logic [AW-1:0]       waddr = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic [NRD*AW-1:0]   raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                iss_valid = 1'b0;
    logic [AW-1:0]       iss_rd = '0;
    logic                flush = 1'b0;
    logic                iss_stall;
    logic [CW-1:0]       busy_cnt;

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .iss_stall(iss_stall), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic cmp_en = 1'b0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: state as plain arrays, updated from the architectural rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else begin
                if (we) m_busy[waddr] = 1'b0;
                if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (!rst || a == 0) return '0;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!rst || a == 0) return 1'b0;
        if (we && waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NRD-1:0] eb;
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("model rdata%0d", p), 64'(rdata[p*XLEN +: XLEN]),
                      64'(exp_rd(raddr[p*AW +: AW])));
                eb[p] = exp_busy(raddr[p*AW +: AW]);
            end
            check("model rbusy", 64'(rbusy), 64'(eb));
            check("model iss_stall", 64'(iss_stall), 64'(rst && iss_valid && (|eb)));
            check("model busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
            check("busy_cnt bound", 64'(busy_cnt <= CW'(NREG - 1)), 64'(1));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        iss_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        // Reset held with a write pending.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; set_ra(5'd5, 5'd5);
        next(); next();
        @(negedge clk);
        check("reset rdata", 64'(rdata), 64'(0));
        check("reset busy_cnt", 64'(busy_cnt), 64'(0));
        next();
        rst = 1'b1; idle();
        @(negedge clk);
        check("post-reset r5", 64'(rdata[31:0]), 64'(0));
        check("post-reset busy_cnt", 64'(busy_cnt), 64'(0));

        // Write then read; then same-cycle bypass.
        next();
        we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
        next();
        idle(); set_ra(5'd3, 5'd0);
        @(negedge clk);
        check("read r3", 64'(rdata[31:0]), 64'h1234_5678);
        next();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5; set_ra(5'd7, 5'd3);
        @(negedge clk);
        check("bypass r7", 64'(rdata[31:0]), 64'hA5A5_A5A5);

        // r0 hardwired.
        next();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        next();
        idle(); set_ra(5'd0, 5'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        @(negedge clk);
        check("read r0", 64'(rdata), 64'(0));
        next();
        idle();
        @(negedge clk);
        check("r0 busy_cnt", 64'(busy_cnt), 64'(0));
        check("r0 rbusy", 64'(rbusy), 64'(0));

        // Scoreboard lifecycle on r9.
        next();
        iss_valid = 1'b1; iss_rd = 5'd9;
        next();
        set_ra(5'd0, 5'd9); iss_rd = 5'd9;
        @(negedge clk);
        check("issue busy_cnt", 64'(busy_cnt), 64'(1));
        check("hazard rbusy1", 64'(rbusy[1]), 64'(1));
        check("hazard stall", 64'(iss_stall), 64'(1));
        next();
        iss_valid = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099;
        @(negedge clk);
        check("wb bypass rbusy1", 64'(rbusy[1]), 64'(0));
        next();
        idle();
        @(negedge clk);
        check("wb busy_cnt", 64'(busy_cnt), 64'(0));

        // Same-register issue and writeback, then disjoint pair.
        next();
        iss_valid = 1'b1; iss_rd = 5'd4;
        next();
        we = 1'b1; waddr = 5'd4; wdata = 32'h4444_0001;
        next();
        idle(); set_ra(5'd4, 5'd6);
        @(negedge clk);
        check("set wins busy_cnt", 64'(busy_cnt), 64'(1));
        check("set wins rbusy", 64'(rbusy), 64'b01);
        next();
        iss_valid = 1'b1; iss_rd = 5'd6; we = 1'b1; waddr = 5'd4; wdata = 32'h4444_0002;
        next();
        idle();
        @(negedge clk);
        check("net zero busy_cnt", 64'(busy_cnt), 64'(1));
        check("net zero rbusy", 64'(rbusy), 64'b10);

        // Flush with a simultaneous issue.
        next();
        we = 1'b1; waddr = 5'd6; wdata = 32'h6666_6666;
        iss_valid = 1'b1; iss_rd = 5'd2;
        next();
        we = 1'b0; iss_rd = 5'd8;
        next();
        iss_rd = 5'd31;
        next();
        idle();
        @(negedge clk);
        check("pre-flush busy_cnt", 64'(busy_cnt), 64'(3));
        next();
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd10;
        next();
        idle(); set_ra(5'd10, 5'd31);
        @(negedge clk);
        check("flush busy_cnt", 64'(busy_cnt), 64'(0));
        check("flush rbusy", 64'(rbusy), 64'(0));
        next();
        set_ra(5'd3, 5'd6);
        @(negedge clk);
        check("flush keeps r3", 64'(rdata[31:0]), 64'h1234_5678);
        check("flush keeps r6", 64'(rdata[63:32]), 64'h6666_6666);

        // Mixed traffic on a narrow address range to exercise hazards.
        for (int n = 0; n < 300; n++) begin
            next();
            we        = 1'($urandom_range(0, 1));
            waddr     = AW'($urandom_range(0, 7));
            wdata     = $urandom;
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            set_ra(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        // Reset asserted mid-cycle with a write pending.
        next();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd12;
        next();
        iss_valid = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE_F00D; set_ra(5'd3, 5'd12);
        #2 rst = 1'b0;
        #1;
        check("async reset rdata", 64'(rdata), 64'(0));
        check("async reset busy_cnt", 64'(busy_cnt), 64'(0));
        next();
        rst = 1'b1; idle();
        @(negedge clk);
        check("reset lost write r3", 64'(rdata[31:0]), 64'(0));
        next();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
